dem_dwa_scheduler: RTL and testbench

Dynamic-element-matching scheduler for the MSB unit-element array of the segmented DAC. It takes the offset-binary MSB code from the segmentation stage and selects that many unit elements each sample, using data-weighted-averaging (DWA) rotation to first-order shape element mismatch. It also sequences array power-up and power-down: idle, mid-scale warm-up, run, and mid-scale mute. Output is a registered one-hot-per-element select word that drives the current-cell array directly.

---
 rtl/dem_dwa_scheduler.sv | 175 +++++++++++++++++
 tb/tb_dem_dwa_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dem_dwa_scheduler.sv
// rtl/dem_dwa_scheduler.sv - DWA unit-element scheduler with warm-up/mute sequencing for the MSB DAC array
// Optional feature macro: DEM_ROTATE_EN (DWA rotation; undefined gives a fixed thermometer code)
module dem_dwa_scheduler #(
  parameter int NUM_ELEM = 16,
  parameter int CODE_W   = 6,
  parameter int MID_CODE = 9,
  parameter int WARM_CYC = 4
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic                en,
  input  logic [CODE_W-1:0]   code_in,
  input  logic                code_vld,
  input  logic                err_clr,
  output logic [NUM_ELEM-1:0] sel_out,
  output logic                ready,
  output logic [1:0]          state,
  output logic                err
);

  localparam int NW = $clog2(NUM_ELEM + 1);
  localparam logic [NW-1:0] N_FULL   = NW'(NUM_ELEM);
  localparam logic [NW-1:0] N_MID    = NW'(MID_CODE);
  localparam logic [7:0]    CNT_LOAD = 8'(WARM_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2,
    MUTE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_ELEM-1:0] sel_q, sel_d;
  logic                err_q, err_d;

  logic                code_over;
  logic [NW-1:0]       n_code;
  logic [NW-1:0]       n_apply;
  logic                apply;
  logic                zero_sel;
  logic                err_set;
  logic [NUM_ELEM-1:0] therm;
  logic [NUM_ELEM-1:0] rot;

  assign code_over = (int'(code_in) > NUM_ELEM);
  assign n_code    = code_over ? N_FULL : NW'(code_in);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    apply    = 1'b0;
    n_apply  = '0;
    zero_sel = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        zero_sel = 1'b1;
        if (en) begin
          state_d = WARM;
          cnt_d   = CNT_LOAD;
          apply   = 1'b1;
          n_apply = N_MID;
        end
      end
      WARM: begin
        if (!en) begin
          state_d = MUTE;
          cnt_d   = CNT_LOAD;
          apply   = 1'b1;
          n_apply = N_MID;
        end else if (cnt_q == 8'd0) begin
          // The edge leaving WARM already carries the first live code.
          state_d = RUN;
          apply   = code_vld;
          n_apply = n_code;
          err_set = code_vld & code_over;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          apply   = 1'b1;
          n_apply = N_MID;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = MUTE;
          cnt_d   = CNT_LOAD;
          apply   = 1'b1;
          n_apply = N_MID;
        end else begin
          apply   = code_vld;
          n_apply = n_code;
          err_set = code_vld & code_over;
        end
      end
      MUTE: begin
        if (cnt_q == 8'd0) begin
          state_d  = IDLE;
          zero_sel = 1'b1;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          apply   = 1'b1;
          n_apply = N_MID;
        end
      end
      default: begin
        state_d  = IDLE;
        zero_sel = 1'b1;
      end
    endcase
  end

  always_comb begin
    therm = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      therm[i] = (i < int'(n_apply));
    end
  end

`ifdef DEM_ROTATE_EN
  localparam int PW = $clog2(NUM_ELEM);
  localparam logic [PW+1:0] N_SUM = (PW+2)'(NUM_ELEM);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW+1:0] ptr_sum;
  logic [PW+1:0] ptr_wrap;

  // Circular rotate of the thermometer mask; a shift by NUM_ELEM yields zero at ptr=0.
  assign rot      = (therm << ptr_q) | (therm >> (NUM_ELEM - int'(ptr_q)));
  assign ptr_sum  = (PW+2)'(ptr_q) + (PW+2)'(n_apply);
  assign ptr_wrap = (ptr_sum >= N_SUM) ? (ptr_sum - N_SUM) : ptr_sum;
  assign ptr_d    = apply ? PW'(ptr_wrap) : ptr_q;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign rot = therm;
`endif

  always_comb begin
    sel_d = sel_q;
    if (apply) begin
      sel_d = rot;
    end else if (zero_sel) begin
      sel_d = '0;
    end
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign sel_out = sel_q;
  assign state   = state_q;
  assign ready   = (state_q == RUN);
  assign err     = err_q;

endmodule

// File: tb/tb_dem_dwa_scheduler.sv
// tb/tb_dem_dwa_scheduler.sv - directed vector table plus randomized reference-model check for dem_dwa_scheduler
module tb_dem_dwa_scheduler;

  localparam int N    = 16;
  localparam int MID  = 9;
  localparam int WARM = 4;

  logic          clock;
  logic          rstn;
  logic          en;
  logic [5:0]    code_in;
  logic          code_vld;
  logic          err_clr;
  logic [N-1:0]  sel_out;
  logic          ready;
  logic [1:0]    state;
  logic          err;

  int checks;
  int errors;

  dem_dwa_scheduler dut (
    .clock    (clock),
    .rstn     (rstn),
    .en       (en),
    .code_in  (code_in),
    .code_vld (code_vld),
    .err_clr  (err_clr),
    .sel_out  (sel_out),
    .ready    (ready),
    .state    (state),
    .err      (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         en;
    logic [5:0]   code;
    logic         vld;
    logic         clr;
    logic [N-1:0] sel;
    logic [1:0]   st;
    logic         er;
  } vec_t;

  vec_t tbl[23];

  // Reference model: phase plus cycles spent in it, pointer as a plain integer.
  int           m_state;
  int           m_cnt;
  int           m_ptr;
  logic [N-1:0] m_sel;
  logic         m_err;

  function automatic vec_t mk(input int e, input int c, input int v, input int cl,
                              input logic [N-1:0] sel_rot, input logic [N-1:0] sel_th,
                              input int s, input int er);
    vec_t r;
    r.en   = (e != 0);
    r.code = 6'(c);
    r.vld  = (v != 0);
    r.clr  = (cl != 0);
`ifdef DEM_ROTATE_EN
    r.sel  = sel_rot;
`else
    r.sel  = sel_th;
`endif
    r.st   = 2'(s);
    r.er   = (er != 0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_ptr   = 0;
    m_sel   = '0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic e, input int code, input logic v, input logic c);
    int n;
    bit use_sel;
    bit over;
    n = 0;
    use_sel = 0;
    over = 0;
    case (m_state)
      0: if (e) begin m_state = 1; m_cnt = 1; use_sel = 1; n = MID; end
         else m_sel = '0;
      1: if (!e) begin m_state = 3; m_cnt = 1; use_sel = 1; n = MID; end
         else if (m_cnt == WARM) begin
           m_state = 2;
           if (v) begin use_sel = 1; over = (code > N); n = over ? N : code; end
         end else begin m_cnt++; use_sel = 1; n = MID; end
      2: if (!e) begin m_state = 3; m_cnt = 1; use_sel = 1; n = MID; end
         else if (v) begin use_sel = 1; over = (code > N); n = over ? N : code; end
      default: if (m_cnt == WARM) begin m_state = 0; m_sel = '0; end
               else begin m_cnt++; use_sel = 1; n = MID; end
    endcase
    if (use_sel) begin
      m_sel = '0;
      for (int k = 0; k < n; k++) m_sel[(m_ptr + k) % N] = 1'b1;
`ifdef DEM_ROTATE_EN
      m_ptr = (m_ptr + n) % N;
`endif
    end
    if (over) m_err = 1'b1;
    else if (c) m_err = 1'b0;
  endtask

  task automatic drive_cycle(input logic e, input logic [5:0] c, input logic v, input logic cl);
    en       = e;
    code_in  = c;
    code_vld = v;
    err_clr  = cl;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tbl[0]  = mk(1,  0, 0, 0, 16'h01FF, 16'h01FF, 1, 0);
    tbl[1]  = mk(1,  0, 0, 0, 16'hFE03, 16'h01FF, 1, 0);
    tbl[2]  = mk(1,  0, 0, 0, 16'h07FC, 16'h01FF, 1, 0);
    tbl[3]  = mk(1,  0, 0, 0, 16'hF80F, 16'h01FF, 1, 0);
    tbl[4]  = mk(1,  5, 1, 0, 16'h01F0, 16'h001F, 2, 0);
    tbl[5]  = mk(1,  7, 1, 0, 16'hFE00, 16'h007F, 2, 0);
    tbl[6]  = mk(1,  6, 1, 0, 16'h003F, 16'h003F, 2, 0);
    tbl[7]  = mk(1,  8, 1, 0, 16'h3FC0, 16'h00FF, 2, 0);
    tbl[8]  = mk(1,  5, 1, 0, 16'hC007, 16'h001F, 2, 0);
    tbl[9]  = mk(1,  0, 1, 0, 16'h0000, 16'h0000, 2, 0);
    tbl[10] = mk(1, 16, 1, 0, 16'hFFFF, 16'hFFFF, 2, 0);
    tbl[11] = mk(1,  3, 0, 0, 16'hFFFF, 16'hFFFF, 2, 0);
    tbl[12] = mk(1, 20, 1, 0, 16'hFFFF, 16'hFFFF, 2, 1);
    tbl[13] = mk(1,  2, 1, 0, 16'h0018, 16'h0003, 2, 1);
    tbl[14] = mk(1,  1, 1, 1, 16'h0020, 16'h0001, 2, 0);
    tbl[15] = mk(1, 31, 1, 1, 16'hFFFF, 16'hFFFF, 2, 1);
    tbl[16] = mk(0,  4, 1, 0, 16'h7FC0, 16'h01FF, 3, 1);
    tbl[17] = mk(1,  4, 1, 0, 16'h80FF, 16'h01FF, 3, 1);
    tbl[18] = mk(0,  0, 0, 0, 16'hFF01, 16'h01FF, 3, 1);
    tbl[19] = mk(1,  0, 0, 0, 16'h03FE, 16'h01FF, 3, 1);
    tbl[20] = mk(0,  0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    tbl[21] = mk(0,  0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    tbl[22] = mk(1,  0, 0, 0, 16'hFC07, 16'h01FF, 1, 1);

    rstn = 1'b1; en = 1'b0; code_in = '0; code_vld = 1'b0; err_clr = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("reset_sel",   32'(sel_out), 32'h0);
    chk("reset_state", 32'(state),   32'h0);
    chk("reset_ready", 32'(ready),   32'h0);
    chk("reset_err",   32'(err),     32'h0);
    @(negedge clock);
    @(negedge clock);
    rstn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive_cycle(tbl[i].en, tbl[i].code, tbl[i].vld, tbl[i].clr);
      chk($sformatf("row%0d_sel", i),   32'(sel_out), 32'(tbl[i].sel));
      chk($sformatf("row%0d_state", i), 32'(state),   32'(tbl[i].st));
      chk($sformatf("row%0d_ready", i), 32'(ready),   32'(tbl[i].st == 2'd2));
      chk($sformatf("row%0d_err", i),   32'(err),     32'(tbl[i].er));
    end

    // Finish the warm-up entered on the last row, then reset from RUN.
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 6'd0, 1'b0, 1'b0);
    chk("midrun_state", 32'(state), 32'h2);
    chk("midrun_ready", 32'(ready), 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("midreset_sel",   32'(sel_out), 32'h0);
    chk("midreset_state", 32'(state),   32'h0);
    chk("midreset_ready", 32'(ready),   32'h0);
    chk("midreset_err",   32'(err),     32'h0);
    @(negedge clock);
    rstn = 1'b1;
    model_reset();

    for (int i = 0; i < 1500; i++) begin
      logic       e;
      logic       v;
      logic       cl;
      int         c;
      e  = ($urandom_range(0, 15) != 0);
      v  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 7) == 0);
      c  = $urandom_range(0, 20);
      if ($urandom_range(0, 15) == 0) c = $urandom_range(17, 63);
      drive_cycle(e, 6'(c), v, cl);
      model_step(e, c, v, cl);
      chk($sformatf("rnd%0d_sel", i),   32'(sel_out), 32'(m_sel));
      chk($sformatf("rnd%0d_state", i), 32'(state),   32'(m_state));
      chk($sformatf("rnd%0d_ready", i), 32'(ready),   32'(m_state == 2));
      chk($sformatf("rnd%0d_err", i),   32'(err),     32'(m_err));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
